// File: rtl/sr_latch_bank.sv
// Registered bank of WIDTH set/reset bits with NOR-latch output semantics,
// a per-bit forbidden-state flag and a saturating forbidden-event counter.
// Optional build macro SR_LATCH_SET_PRIORITY_EN: S=R=1 acts as set, no flags.
module sr_latch_bank #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] q_bar,
  output logic [WIDTH-1:0] invalid,
  output logic [CNT_W-1:0] invalid_cnt
);

  logic [WIDTH-1:0] st_reg, st_next;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [WIDTH-1:0] q_bar_reg, q_bar_next;
  logic [WIDTH-1:0] invalid_reg, invalid_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             any_invalid;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_bit
      logic st_n, q_n, q_bar_n, inv_n;

      always_comb begin
        st_n    = st_reg[gi];
        q_n     = st_reg[gi];
        q_bar_n = ~st_reg[gi];
        inv_n   = 1'b0;
        unique case ({s[gi], r[gi]})
          2'b10: begin
            st_n    = 1'b1;
            q_n     = 1'b1;
            q_bar_n = 1'b0;
          end
          2'b01: begin
            st_n    = 1'b0;
            q_n     = 1'b0;
            q_bar_n = 1'b1;
          end
          2'b11: begin
`ifdef SR_LATCH_SET_PRIORITY_EN
            st_n    = 1'b1;
            q_n     = 1'b1;
            q_bar_n = 1'b0;
`else
            // Stored state survives the forbidden interval so release is deterministic.
            q_n     = 1'b0;
            q_bar_n = 1'b0;
            inv_n   = 1'b1;
`endif
          end
          default: begin
            st_n = st_reg[gi];
          end
        endcase
      end

      assign st_next[gi]      = st_n;
      assign q_next[gi]       = q_n;
      assign q_bar_next[gi]   = q_bar_n;
      assign invalid_next[gi] = inv_n;
    end
  endgenerate

  // One count per edge regardless of how many bits are forbidden.
  assign any_invalid = |invalid_next;

  always_comb begin
    cnt_next = cnt_reg;
    if (any_invalid && (cnt_reg != {CNT_W{1'b1}})) begin
      cnt_next = cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_reg      <= '0;
      q_reg       <= '0;
      q_bar_reg   <= '1;
      invalid_reg <= '0;
      cnt_reg     <= '0;
    end else begin
      st_reg      <= st_next;
      q_reg       <= q_next;
      q_bar_reg   <= q_bar_next;
      invalid_reg <= invalid_next;
      cnt_reg     <= cnt_next;
    end
  end

  assign q           = q_reg;
  assign q_bar       = q_bar_reg;
  assign invalid     = invalid_reg;
  assign invalid_cnt = cnt_reg;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Scoreboard bench for sr_latch_bank: a 4-bit/8-bit-counter instance and a
// 1-bit/2-bit-counter instance driven in lockstep against a behavioural model.
module tb_sr_latch_bank;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] sa = '0, ra = '0, qa, qba, inva;
  logic [7:0] cnta;
  logic [0:0] sb = '0, rb = '0, qb, qbb, invb;
  logic [1:0] cntb;

  always #5 clk = ~clk;

  sr_latch_bank #(.WIDTH(4), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n), .s(sa), .r(ra),
    .q(qa), .q_bar(qba), .invalid(inva), .invalid_cnt(cnta)
  );

  sr_latch_bank #(.WIDTH(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .s(sb), .r(rb),
    .q(qb), .q_bar(qbb), .invalid(invb), .invalid_cnt(cntb)
  );

  typedef struct packed {
    logic [3:0] q;
    logic [3:0] qb;
    logic [3:0] inv;
    logic [7:0] cnt;
  } exp_a_t;

  typedef struct packed {
    logic       q;
    logic       qb;
    logic       inv;
    logic [1:0] cnt;
  } exp_b_t;

  exp_a_t sb_a[$];
  exp_b_t sb_b[$];

  logic [3:0] m_st_a = '0;
  logic [7:0] m_cnt_a = '0;
  logic       m_st_b = 1'b0;
  logic [1:0] m_cnt_b = '0;

  int n_checks = 0;
  int n_fail   = 0;

  // Applies one edge of stimulus to both instances and queues the expected outputs.
  task automatic drive(input logic rst, input logic [3:0] s4, input logic [3:0] r4,
                       input logic s1, input logic r1);
    exp_a_t ea;
    exp_b_t eb;
    logic [3:0] fa;
    logic       fb;
    @(negedge clk);
    rst_n = ~rst;
    sa = s4; ra = r4; sb = s1; rb = r1;
    fa = '0;
    fb = 1'b0;
    if (rst) begin
      m_st_a = '0; m_cnt_a = '0; m_st_b = 1'b0; m_cnt_b = '0;
    end else begin
`ifdef SR_LATCH_SET_PRIORITY_EN
      m_st_a = s4 | (m_st_a & ~r4);
      m_st_b = s1 | (m_st_b & ~r1);
`else
      fa = s4 & r4;
      fb = s1 & r1;
      m_st_a = (s4 & ~r4) | (m_st_a & ~(r4 & ~s4));
      m_st_b = (s1 & ~r1) | (m_st_b & ~(r1 & ~s1));
`endif
      if ((|fa) && m_cnt_a != 8'hFF) m_cnt_a = m_cnt_a + 8'd1;
      if (fb && m_cnt_b != 2'b11) m_cnt_b = m_cnt_b + 2'd1;
    end
    ea.q = m_st_a & ~fa; ea.qb = ~m_st_a & ~fa; ea.inv = fa; ea.cnt = m_cnt_a;
    eb.q = m_st_b & ~fb; eb.qb = ~m_st_b & ~fb; eb.inv = fb; eb.cnt = m_cnt_b;
    sb_a.push_back(ea);
    sb_b.push_back(eb);
    @(posedge clk);
    #1;
    $display("t=%0t rst=%b sa=%b ra=%b sb=%b rb=%b | qa=%b qba=%b inva=%b cnta=%0d | qb=%b qbb=%b invb=%b cntb=%0d",
             $time, rst, s4, r4, s1, r1, qa, qba, inva, cnta, qb, qbb, invb, cntb);
  endtask

  task automatic test_reset();
    exp_a_t ea;
    exp_b_t eb;
    for (int i = 0; i < 3; i++) begin
      if (i < 2) drive(1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
      else       drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
      ea = sb_a.pop_front();
      eb = sb_b.pop_front();
      n_checks++;
      if ({qa, qba, inva, cnta} !== ea) begin
        n_fail++;
        $display("FAIL reset_a step %0d: got q=%b q_bar=%b inv=%b cnt=%0d want q=%b q_bar=%b inv=%b cnt=%0d",
                 i, qa, qba, inva, cnta, ea.q, ea.qb, ea.inv, ea.cnt);
      end
      n_checks++;
      if ({qb, qbb, invb, cntb} !== eb) begin
        n_fail++;
        $display("FAIL reset_b step %0d: got %b%b%b cnt=%0d want %b%b%b cnt=%0d",
                 i, qb, qbb, invb, cntb, eb.q, eb.qb, eb.inv, eb.cnt);
      end
    end
  endtask

  // Single-bit sequences applied to dut_b and bit 0 of dut_a alike.
  task automatic test_single_seq(input string name, input logic [1:0] cmd [],
                                 input int reps []);
    exp_a_t ea;
    exp_b_t eb;
    for (int k = 0; k < cmd.size(); k++) begin
      for (int j = 0; j < reps[k]; j++) begin
        drive(1'b0, {3'b000, cmd[k][1]}, {3'b000, cmd[k][0]}, cmd[k][1], cmd[k][0]);
        ea = sb_a.pop_front();
        eb = sb_b.pop_front();
        n_checks++;
        if ({qa, qba, inva, cnta} !== ea) begin
          n_fail++;
          $display("FAIL %s_a seg %0d rep %0d: got q=%b q_bar=%b inv=%b cnt=%0d want q=%b q_bar=%b inv=%b cnt=%0d",
                   name, k, j, qa, qba, inva, cnta, ea.q, ea.qb, ea.inv, ea.cnt);
        end
        n_checks++;
        if ({qb, qbb, invb, cntb} !== eb) begin
          n_fail++;
          $display("FAIL %s_b seg %0d rep %0d: got q=%b q_bar=%b inv=%b cnt=%0d want q=%b q_bar=%b inv=%b cnt=%0d",
                   name, k, j, qb, qbb, invb, cntb, eb.q, eb.qb, eb.inv, eb.cnt);
        end
      end
    end
  endtask

  task automatic test_saturation();
    exp_b_t eb;
    logic [1:0] want [7] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    void'(sb_a.pop_front());
    void'(sb_b.pop_front());
    for (int i = 0; i < 7; i++) begin
      if (i < 6) drive(1'b0, 4'h1, 4'h1, 1'b1, 1'b1);
      else       drive(1'b1, 4'h1, 4'h1, 1'b1, 1'b1);
      void'(sb_a.pop_front());
      eb = sb_b.pop_front();
`ifndef SR_LATCH_SET_PRIORITY_EN
      n_checks++;
      if (cntb !== want[i]) begin
        n_fail++;
        $display("FAIL saturation step %0d: got cnt=%0d want %0d", i, cntb, want[i]);
      end
`endif
      n_checks++;
      if ({qb, qbb, invb, cntb} !== eb) begin
        n_fail++;
        $display("FAIL saturation_b step %0d: got q=%b q_bar=%b inv=%b cnt=%0d want q=%b q_bar=%b inv=%b cnt=%0d",
                 i, qb, qbb, invb, cntb, eb.q, eb.qb, eb.inv, eb.cnt);
      end
    end
  endtask

  task automatic test_multibit();
    exp_a_t ea;
    logic [3:0] s_tab [3] = '{4'b0000, 4'b1010, 4'b0000};
    logic [3:0] r_tab [3] = '{4'b0000, 4'b0110, 4'b0000};
    drive(1'b1, 4'h0, 4'h0, 1'b0, 1'b0);
    void'(sb_a.pop_front());
    void'(sb_b.pop_front());
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, s_tab[i], r_tab[i], 1'b0, 1'b0);
      ea = sb_a.pop_front();
      void'(sb_b.pop_front());
      n_checks++;
      if ({qa, qba, inva, cnta} !== ea) begin
        n_fail++;
        $display("FAIL multibit step %0d: got q=%b q_bar=%b inv=%b cnt=%0d want q=%b q_bar=%b inv=%b cnt=%0d",
                 i, qa, qba, inva, cnta, ea.q, ea.qb, ea.inv, ea.cnt);
      end
    end
  endtask

  task automatic test_rst_glitch();
    exp_a_t ea;
    drive(1'b0, 4'b0101, 4'b0000, 1'b1, 1'b0);
    void'(sb_a.pop_front());
    void'(sb_b.pop_front());
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    drive(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    ea = sb_a.pop_front();
    void'(sb_b.pop_front());
    n_checks++;
    if ({qa, qba, inva, cnta} !== ea) begin
      n_fail++;
      $display("FAIL rst_glitch: got q=%b q_bar=%b inv=%b cnt=%0d want q=%b q_bar=%b inv=%b cnt=%0d",
               qa, qba, inva, cnta, ea.q, ea.qb, ea.inv, ea.cnt);
    end
  endtask

  task automatic test_back_to_back();
    exp_a_t ea;
    exp_b_t eb;
    for (int i = 0; i < 40; i++) begin
      drive(($urandom_range(0, 15) == 0), 4'($urandom), 4'($urandom),
            1'($urandom), 1'($urandom));
      ea = sb_a.pop_front();
      eb = sb_b.pop_front();
      n_checks++;
      if ({qa, qba, inva, cnta} !== ea) begin
        n_fail++;
        $display("FAIL b2b_a step %0d: got q=%b q_bar=%b inv=%b cnt=%0d want q=%b q_bar=%b inv=%b cnt=%0d",
                 i, qa, qba, inva, cnta, ea.q, ea.qb, ea.inv, ea.cnt);
      end
      n_checks++;
      if ({qb, qbb, invb, cntb} !== eb) begin
        n_fail++;
        $display("FAIL b2b_b step %0d: got q=%b q_bar=%b inv=%b cnt=%0d want q=%b q_bar=%b inv=%b cnt=%0d",
                 i, qb, qbb, invb, cntb, eb.q, eb.qb, eb.inv, eb.cnt);
      end
    end
  endtask

  initial begin
    logic [1:0] c1 [] = '{2'b10, 2'b11, 2'b00};
    int         r1 [] = '{1, 3, 1};
    logic [1:0] c2 [] = '{2'b01, 2'b11, 2'b00};
    int         r2 [] = '{6, 9, 1};
    test_reset();
    test_single_seq("set_forbidden", c1, r1);
    test_single_seq("reset_forbidden", c2, r2);
    test_saturation();
    test_multibit();
    test_rst_glitch();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
